pipe_stage_buf: RTL

- Parametrised elastic pipeline-stage register; the next generation of the fixed inter-stage latches (ID/EX, EX/MEM, MEM/WB).
- Carries an opaque DATA_W payload through a DEPTH-entry circular buffer using a valid/ready handshake.
- Supports an exception/branch flush that kills every in-flight beat while preserving a KEEP_MASK-selected field, such as the PC used for the EPC.
- Sits between any two CPU pipeline stages.

---
 rtl/pipe_pkg.sv | 17 +
 rtl/pipe_stage_ptr.sv | 27 ++
 rtl/pipe_stage_buf.sv | 119 +++++++++++
 3 files changed

// File: rtl/pipe_pkg.sv
// pipe_pkg: shared constants and sizing helpers for the elastic pipeline stage.
package pipe_pkg;

    localparam int PIPE_STATS_W   = 16;
    localparam int PIPE_MAX_DEPTH = 4;

    // Width needed to hold a count of 0..depth inclusive.
    function automatic int clog2_p1(input int depth);
        return $clog2(depth + 1);
    endfunction

    // Pointer width; a single-entry buffer still needs a one-bit pointer.
    function automatic int ptr_w(input int depth);
        return (depth > 1) ? $clog2(depth) : 1;
    endfunction

endpackage

// File: rtl/pipe_stage_ptr.sv
// pipe_stage_ptr: wrapping read/write pointer for a DEPTH-entry circular buffer.
// Wraps DEPTH-1 -> 0 explicitly so non-power-of-two depths work.
module pipe_stage_ptr
    import pipe_pkg::*;
#(
    parameter int DEPTH = 2
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      inc,
    input  logic                      clr,
    output logic [ptr_w(DEPTH)-1:0]   ptr
);

    localparam int PW = ptr_w(DEPTH);

    // Clear wins over increment so a flush always realigns the pointer.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst)
            ptr <= '0;
        else if (clr)
            ptr <= '0;
        else if (inc)
            ptr <= (ptr == PW'(DEPTH - 1)) ? '0 : ptr + 1'b1;
    end

endmodule

// File: rtl/pipe_stage_buf.sv
// pipe_stage_buf: elastic valid/ready pipeline-stage register with flush.
// Beats travel through a DEPTH-entry circular buffer in FIFO order. A flush
// drops all buffered beats; the KEEP_MASK field of the last offered beat is
// retained and shown on out_data while the stage is empty.
// Optional stall/flush statistics counters: define PIPE_STAGE_STATS_EN.
module pipe_stage_buf
    import pipe_pkg::*;
#(
    parameter int                DATA_W    = 64,
    parameter int                DEPTH     = 2,
    parameter logic [DATA_W-1:0] KEEP_MASK = '0
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       flush,
    input  logic                       in_valid,
    output logic                       in_ready,
    input  logic [DATA_W-1:0]          in_data,
    output logic                       out_valid,
    input  logic                       out_ready,
    output logic [DATA_W-1:0]          out_data,
    output logic [clog2_p1(DEPTH)-1:0] occupancy,
    output logic [PIPE_STATS_W-1:0]    stall_cycles,
    output logic [PIPE_STATS_W-1:0]    flush_count
);

    localparam int CW = clog2_p1(DEPTH);
    localparam int PW = ptr_w(DEPTH);

    if (DEPTH < 1 || DEPTH > PIPE_MAX_DEPTH) begin : g_bad_depth
        $error("pipe_stage_buf: DEPTH must be in 1..4");
    end

    logic [DEPTH-1:0][DATA_W-1:0] storage;
    logic [CW-1:0]                count;
    logic [PW-1:0]                wr_ptr;
    logic [PW-1:0]                rd_ptr;
    logic [DATA_W-1:0]            keep_q;
    logic                         push;
    logic                         pop;

    // Handshake decode; ready depends only on registered count.
    assign in_ready  = (count < CW'(DEPTH));
    assign out_valid = (count != '0);
    assign push      = in_valid && in_ready && !flush;
    assign pop       = out_valid && out_ready && !flush;
    assign occupancy = count;
    assign out_data  = out_valid ? storage[rd_ptr] : keep_q;

    pipe_stage_ptr #(.DEPTH(DEPTH)) u_wr_ptr (
        .clk (clk),
        .rst (rst),
        .inc (push),
        .clr (flush),
        .ptr (wr_ptr)
    );

    pipe_stage_ptr #(.DEPTH(DEPTH)) u_rd_ptr (
        .clk (clk),
        .rst (rst),
        .inc (pop),
        .clr (flush),
        .ptr (rd_ptr)
    );

    // Occupancy tracking; flush empties the stage regardless of handshakes.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst)
            count <= '0;
        else if (flush)
            count <= '0;
        else if (push && !pop)
            count <= count + 1'b1;
        else if (pop && !push)
            count <= count - 1'b1;
    end

    // Payload storage written at the write pointer on each accepted beat.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst)
            storage <= '0;
        else if (push)
            storage[wr_ptr] <= in_data;
    end

    // Keep field follows every offered beat that is stored or coincides with
    // a flush, so the faulting PC survives even though its beat is killed.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst)
            keep_q <= '0;
        else if (in_valid && (push || flush))
            keep_q <= in_data & KEEP_MASK;
    end

`ifdef PIPE_STAGE_STATS_EN
    logic [PIPE_STATS_W-1:0] stall_q;
    logic [PIPE_STATS_W-1:0] flush_q;

    // Saturating stall and flush event counters.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            stall_q <= '0;
            flush_q <= '0;
        end else begin
            if (in_valid && !in_ready && !flush && stall_q != '1)
                stall_q <= stall_q + 1'b1;
            if (flush && flush_q != '1)
                flush_q <= flush_q + 1'b1;
        end
    end

    assign stall_cycles = stall_q;
    assign flush_count  = flush_q;
`else
    assign stall_cycles = '0;
    assign flush_count  = '0;
`endif

endmodule
